glitch_pulse_gen: RTL and testbench

Timing core downstream of the UART command decoder inside the glitcher top level.
- Takes delay, width and edge-select configuration and an arm strobe from the decoder.
- Waits for a qualified edge on the external target trigger, counts the programmed delay in clock cycles, then drives the glitch pulse for the programmed width.
- Reports busy and done status back to the decoder.

---
 rtl/glitch_pkg.sv | 21 ++
 rtl/glitch_pulse_gen_sync_edge_det.sv | 42 ++++
 rtl/glitch_pulse_gen.sv | 191 +++++++++++++++++++
 tb/tb_glitch_pulse_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch pulse generator.
package glitch_pkg;

  // Default counter and configuration widths
  localparam int DELAY_W_DEF   = 32;
  localparam int WIDTH_W_DEF   = 16;
  localparam int TIMEOUT_W_DEF = 32;

  // Trigger edge-select encodings
  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    PULSE = 2'd3
  } state_e;

endpackage

// File: rtl/glitch_pulse_gen_sync_edge_det.sv
// Multi-stage synchroniser for an asynchronous input followed by a
// registered edge detector. rise_o/fall_o are one-cycle pulses.
// SYNC_STAGES must be at least 2.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchronise the input, keep its previous value and register edge flags
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values and the shift chain does not collapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_out;
      rise_q <= sync_out & ~prev_q;
      fall_q <= ~sync_out & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/glitch_pulse_gen.sv
// Glitch timing core: arm with a configuration, wait for a qualified edge on
// the external trigger, count the programmed delay, then drive a registered
// pulse for the programmed width.
// Optional feature macro: GLITCH_TIMEOUT_EN (bounded wait in ARMED with a
// timeout_o strobe). Without it, ARMED waits forever and timeout_o is 0.
module glitch_pulse_gen
  import glitch_pkg::*;
#(
  parameter int DELAY_W     = DELAY_W_DEF,
  parameter int WIDTH_W     = WIDTH_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = TIMEOUT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic                 edge_sel_i,
  input  logic [DELAY_W-1:0]   delay_i,
  input  logic [WIDTH_W-1:0]   width_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 trigger_i,
  output logic                 pulse_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o
);

  state_e               state_q, state_d;
  logic                 edge_sel_q, edge_sel_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [DELAY_W-1:0]   delay_cnt_q, delay_cnt_d;
  logic [WIDTH_W-1:0]   width_cnt_q, width_cnt_d;
  logic                 pulse_q, pulse_d;
  logic                 done_q, done_d;
  logic                 trig_rise, trig_fall;
  logic                 qual_edge;
  logic [WIDTH_W-1:0]   width_load;

`ifdef GLITCH_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_lim_q, tmo_lim_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_strobe_q, tmo_strobe_d;
`else
  logic                 unused_timeout;
  assign unused_timeout = ^timeout_i;
`endif

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_trig_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (trigger_i),
    .rise_o  (trig_rise),
    .fall_o  (trig_fall)
  );

  assign qual_edge  = (edge_sel_q == EDGE_FALL) ? trig_fall : trig_rise;
  // A programmed width of 0 still yields a single-cycle pulse
  assign width_load = (width_q == '0) ? '0 : width_q - WIDTH_W'(1);

  // Next-state, counter and output decode for the sequencer
  // NOTE: every target gets a default first so no path leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    edge_sel_d  = edge_sel_q;
    delay_d     = delay_q;
    width_d     = width_q;
    delay_cnt_d = delay_cnt_q;
    width_cnt_d = width_cnt_q;
    pulse_d     = 1'b0;
    done_d      = 1'b0;
`ifdef GLITCH_TIMEOUT_EN
    tmo_lim_d    = tmo_lim_q;
    tmo_cnt_d    = tmo_cnt_q;
    tmo_strobe_d = 1'b0;
`endif

    if (abort_i) begin
      // Abort beats everything, including a simultaneous arm
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_d    = ARMED;
            edge_sel_d = edge_sel_i;
            delay_d    = delay_i;
            width_d    = width_i;
`ifdef GLITCH_TIMEOUT_EN
            tmo_lim_d  = timeout_i;
            tmo_cnt_d  = '0;
`endif
          end
        end

        ARMED: begin
          if (qual_edge) begin
            if (delay_q == '0) begin
              state_d     = PULSE;
              pulse_d     = 1'b1;
              width_cnt_d = width_load;
            end else begin
              state_d     = DELAY;
              delay_cnt_d = delay_q - DELAY_W'(1);
            end
`ifdef GLITCH_TIMEOUT_EN
          end else if ((tmo_lim_q != '0) && (tmo_cnt_q == tmo_lim_q - TIMEOUT_W'(1))) begin
            state_d      = IDLE;
            tmo_strobe_d = 1'b1;
          end else if (tmo_cnt_q != '1) begin
            tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
`endif
          end
        end

        DELAY: begin
          if (delay_cnt_q == '0) begin
            state_d     = PULSE;
            pulse_d     = 1'b1;
            width_cnt_d = width_load;
          end else begin
            delay_cnt_d = delay_cnt_q - DELAY_W'(1);
          end
        end

        PULSE: begin
          if (width_cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            pulse_d     = 1'b1;
            width_cnt_d = width_cnt_q - WIDTH_W'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer state, latched configuration, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      edge_sel_q  <= EDGE_RISE;
      delay_q     <= '0;
      width_q     <= '0;
      delay_cnt_q <= '0;
      width_cnt_q <= '0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      edge_sel_q  <= edge_sel_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
      delay_cnt_q <= delay_cnt_d;
      width_cnt_q <= width_cnt_d;
      pulse_q     <= pulse_d;
      done_q      <= done_d;
    end
  end

`ifdef GLITCH_TIMEOUT_EN
  // Timeout limit, ARMED wait counter and expiry strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_lim_q    <= '0;
      tmo_cnt_q    <= '0;
      tmo_strobe_q <= 1'b0;
    end else begin
      tmo_lim_q    <= tmo_lim_d;
      tmo_cnt_q    <= tmo_cnt_d;
      tmo_strobe_q <= tmo_strobe_d;
    end
  end

  assign timeout_o = tmo_strobe_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign pulse_o = pulse_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Directed self-checking bench for glitch_pulse_gen. Inputs change and
// outputs are sampled on the falling clock edge. Index j counts rising edges
// after the one that first samples a trigger change (j=0) or accepts an arm.
module tb_glitch_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm_i, abort_i, edge_sel_i, trigger_i;
  logic [31:0] delay_i;
  logic [15:0] width_i;
  logic [31:0] timeout_i;
  logic        pulse_o, busy_o, done_o, timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  glitch_pulse_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm_i      (arm_i),
    .abort_i    (abort_i),
    .edge_sel_i (edge_sel_i),
    .delay_i    (delay_i),
    .width_i    (width_i),
    .timeout_i  (timeout_i),
    .trigger_i  (trigger_i),
    .pulse_o    (pulse_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .timeout_o  (timeout_o)
  );

  // One-cycle arm strobe; returns on the falling edge after acceptance
  task automatic arm_cfg(input logic e, input logic [31:0] d, input logic [15:0] w,
                         input logic [31:0] t);
    @(negedge clk);
    edge_sel_i = e; delay_i = d; width_i = w; timeout_i = t; arm_i = 1'b1;
    @(negedge clk);
    arm_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; arm_i = 1'b0; abort_i = 1'b0; edge_sel_i = 1'b0; trigger_i = 1'b0;
    delay_i = '0; width_i = '0; timeout_i = '0;
    #1;
    n_checks++; if (pulse_o !== 1'b0) $display("FAIL reset_pulse got %b want 0", pulse_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
    n_checks++; if (done_o !== 1'b0) $display("FAIL reset_done got %b want 0", done_o); else n_pass++;
    n_checks++; if (timeout_o !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout_o); else n_pass++;
    arm_i = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_arm_held got %b want 0", busy_o); else n_pass++;
    arm_i = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rising;
    arm_cfg(1'b0, 32'd10, 16'd5, 32'd0);
    repeat (3) @(negedge clk);
    trigger_i = 1'b1;
    for (int j = 0; j <= 22; j++) begin
      @(negedge clk);
      n_checks++; if (pulse_o !== (j >= 13 && j <= 17)) $display("FAIL rise_pulse j=%0d got %b want %b", j, pulse_o, (j >= 13 && j <= 17)); else n_pass++;
      n_checks++; if (done_o !== (j == 18)) $display("FAIL rise_done j=%0d got %b want %b", j, done_o, (j == 18)); else n_pass++;
      n_checks++; if (busy_o !== (j < 18)) $display("FAIL rise_busy j=%0d got %b want %b", j, busy_o, (j < 18)); else n_pass++;
    end
    // Falling edge while IDLE must be discarded
    trigger_i = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      n_checks++; if (pulse_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL rise_idle_edge j=%0d got pulse=%b busy=%b want 0/0", j, pulse_o, busy_o); else n_pass++;
    end
  endtask

  task automatic test_zero;
    arm_cfg(1'b0, 32'd0, 16'd0, 32'd0);
    repeat (3) @(negedge clk);
    trigger_i = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      n_checks++; if (pulse_o !== (j == 3)) $display("FAIL zero_pulse j=%0d got %b want %b", j, pulse_o, (j == 3)); else n_pass++;
      n_checks++; if (done_o !== (j == 4)) $display("FAIL zero_done j=%0d got %b want %b", j, done_o, (j == 4)); else n_pass++;
      n_checks++; if (busy_o !== (j < 4)) $display("FAIL zero_busy j=%0d got %b want %b", j, busy_o, (j < 4)); else n_pass++;
    end
    // Rising-edge arm, then a falling edge: must stay armed with no pulse
    arm_cfg(1'b0, 32'd5, 16'd1, 32'd0);
    repeat (2) @(negedge clk);
    trigger_i = 1'b0;
    for (int j = 0; j <= 11; j++) begin
      @(negedge clk);
      n_checks++; if (pulse_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL zero_wrong_edge j=%0d got pulse=%b busy=%b want 0/1", j, pulse_o, busy_o); else n_pass++;
    end
    @(negedge clk); abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL zero_abort_armed got busy=%b done=%b want 0/0", busy_o, done_o); else n_pass++;
  endtask

  task automatic test_edge_sel;
    trigger_i = 1'b1;
    repeat (5) @(negedge clk);
    arm_cfg(1'b1, 32'd4, 16'd2, 32'd0);
    for (int j = 0; j <= 7; j++) begin
      @(negedge clk);
      n_checks++; if (pulse_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL fall_preassert j=%0d got pulse=%b busy=%b want 0/1", j, pulse_o, busy_o); else n_pass++;
    end
    trigger_i = 1'b0;
    for (int j = 0; j <= 11; j++) begin
      @(negedge clk);
      n_checks++; if (pulse_o !== (j >= 7 && j <= 8)) $display("FAIL fall_pulse j=%0d got %b want %b", j, pulse_o, (j >= 7 && j <= 8)); else n_pass++;
      n_checks++; if (done_o !== (j == 9)) $display("FAIL fall_done j=%0d got %b want %b", j, done_o, (j == 9)); else n_pass++;
      n_checks++; if (busy_o !== (j < 9)) $display("FAIL fall_busy j=%0d got %b want %b", j, busy_o, (j < 9)); else n_pass++;
    end
  endtask

  task automatic test_abort;
    repeat (3) @(negedge clk);
    arm_cfg(1'b0, 32'd0, 16'd100, 32'd0);
    repeat (2) @(negedge clk);
    trigger_i = 1'b1;
    for (int j = 0; j <= 22; j++) begin
      @(negedge clk);
      n_checks++; if (pulse_o !== (j >= 3)) $display("FAIL abort_pulse j=%0d got %b want %b", j, pulse_o, (j >= 3)); else n_pass++;
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    n_checks++; if (pulse_o !== 1'b0) $display("FAIL abort_pulse_low got %b want 0", pulse_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL abort_busy got %b want 0", busy_o); else n_pass++;
    for (int j = 0; j < 5; j++) begin
      n_checks++; if (done_o !== 1'b0) $display("FAIL abort_no_done j=%0d got %b want 0", j, done_o); else n_pass++;
      @(negedge clk);
    end
    // Abort together with arm in IDLE: stays IDLE
    arm_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    arm_i = 1'b0; abort_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      n_checks++; if (busy_o !== 1'b0) $display("FAIL abort_vs_arm j=%0d got %b want 0", j, busy_o); else n_pass++;
      @(negedge clk);
    end
    // Second arm behaves normally
    trigger_i = 1'b0;
    repeat (4) @(negedge clk);
    arm_cfg(1'b0, 32'd2, 16'd3, 32'd0);
    repeat (2) @(negedge clk);
    trigger_i = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      n_checks++; if (pulse_o !== (j >= 5 && j <= 7)) $display("FAIL rearm_pulse j=%0d got %b want %b", j, pulse_o, (j >= 5 && j <= 7)); else n_pass++;
      n_checks++; if (done_o !== (j == 8)) $display("FAIL rearm_done j=%0d got %b want %b", j, done_o, (j == 8)); else n_pass++;
      n_checks++; if (busy_o !== (j < 8)) $display("FAIL rearm_busy j=%0d got %b want %b", j, busy_o, (j < 8)); else n_pass++;
    end
  endtask

  task automatic test_ignored_arm;
    trigger_i = 1'b0;
    repeat (4) @(negedge clk);
    arm_cfg(1'b0, 32'd6, 16'd2, 32'd0);
    repeat (2) @(negedge clk);
    trigger_i = 1'b1;
    for (int j = 0; j <= 13; j++) begin
      @(negedge clk);
      n_checks++; if (pulse_o !== (j >= 9 && j <= 10)) $display("FAIL ign_arm_pulse j=%0d got %b want %b", j, pulse_o, (j >= 9 && j <= 10)); else n_pass++;
      n_checks++; if (done_o !== (j == 11)) $display("FAIL ign_arm_done j=%0d got %b want %b", j, done_o, (j == 11)); else n_pass++;
      n_checks++; if (busy_o !== (j < 11)) $display("FAIL ign_arm_busy j=%0d got %b want %b", j, busy_o, (j < 11)); else n_pass++;
      if (j == 5) begin arm_i = 1'b1; delay_i = 32'd1; width_i = 16'd7; edge_sel_i = 1'b1; end
      if (j == 6) arm_i = 1'b0;
    end
    // Asynchronous reset in the middle of DELAY
    trigger_i = 1'b0;
    repeat (4) @(negedge clk);
    arm_cfg(1'b0, 32'd20, 16'd4, 32'd0);
    repeat (2) @(negedge clk);
    trigger_i = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++; if (busy_o !== 1'b1) $display("FAIL rst_pre_busy got %b want 1", busy_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_async_busy got %b want 0", busy_o); else n_pass++;
    n_checks++; if (pulse_o !== 1'b0 || done_o !== 1'b0 || timeout_o !== 1'b0) $display("FAIL rst_async_outs got pulse=%b done=%b to=%b want 0/0/0", pulse_o, done_o, timeout_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      n_checks++; if (pulse_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL rst_after j=%0d got pulse=%b busy=%b want 0/0", j, pulse_o, busy_o); else n_pass++;
    end
  endtask

  task automatic test_timeout;
    trigger_i = 1'b0;
    repeat (4) @(negedge clk);
    arm_cfg(1'b0, 32'd0, 16'd1, 32'd50);
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
`ifdef GLITCH_TIMEOUT_EN
      n_checks++; if (timeout_o !== (j == 50)) $display("FAIL tmo_strobe j=%0d got %b want %b", j, timeout_o, (j == 50)); else n_pass++;
      n_checks++; if (busy_o !== (j < 50)) $display("FAIL tmo_busy j=%0d got %b want %b", j, busy_o, (j < 50)); else n_pass++;
`else
      n_checks++; if (timeout_o !== 1'b0) $display("FAIL tmo_strobe j=%0d got %b want 0", j, timeout_o); else n_pass++;
      n_checks++; if (busy_o !== 1'b1) $display("FAIL tmo_busy j=%0d got %b want 1", j, busy_o); else n_pass++;
`endif
      n_checks++; if (pulse_o !== 1'b0) $display("FAIL tmo_pulse j=%0d got %b want 0", j, pulse_o); else n_pass++;
    end
    @(negedge clk); abort_i = 1'b1;
    @(negedge clk); abort_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0 || timeout_o !== 1'b0) $display("FAIL tmo_cleanup got busy=%b to=%b want 0/0", busy_o, timeout_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rising();
    test_zero();
    test_edge_sel();
    test_abort();
    test_ignored_arm();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
